bus_mem_ctrl: RTL and testbench



---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_mem_array.sv | 81 ++++++++
 rtl/bus_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_bus_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: default data/address widths (common with DR and AR),
// memory-controller FSM states and the captured operation code.
package bus_pkg;

    localparam int BUS_DATA_W = 16;
    localparam int BUS_ADDR_W = 12;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/bus_mem_array.sv
// Synchronous single-port RAM with a registered, held read port.
// With BUS_MEM_PARITY_EN defined each word carries an even-parity bit and par_err flags a bad read.
module bus_mem_array
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DEPTH  = 2 ** BUS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef BUS_MEM_PARITY_EN
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] rdata
);

`ifdef BUS_MEM_PARITY_EN
    localparam int PAR_W = 1;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int PAR_W = 0;
`endif

    localparam int WORD_W = DATA_W + PAR_W;

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rd_word_s;
    logic [DATA_W-1:0] rdata_r;
`ifdef BUS_MEM_PARITY_EN
    logic              par_err_r;
`endif

    // Combinational view of the addressed word, consumed only by the read register.
    always_comb begin
        rd_word_s = mem_r[addr];
    end

    // Write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
`ifdef BUS_MEM_PARITY_EN
            mem_r[addr] <= {even_par(wdata), wdata};
`else
            mem_r[addr] <= wdata;
`endif
        end
    end

    // Registered read data, held between reads; the parity flag is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r   <= '0;
`ifdef BUS_MEM_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            if (re) begin
                rdata_r <= rd_word_s[DATA_W-1:0];
            end else begin
                rdata_r <= rdata_r;
            end
`ifdef BUS_MEM_PARITY_EN
            par_err_r <= re && (even_par(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W]);
`endif
        end
    end

    assign rdata   = rdata_r;
`ifdef BUS_MEM_PARITY_EN
    assign par_err = par_err_r;
`endif

endmodule

// File: rtl/bus_mem_ctrl.sv
// Bus memory unit upstream of DR: captures RD/WR requests, inserts WAIT_CYCLES wait states,
// then accesses bus_mem_array. Optional even-parity checking with BUS_MEM_PARITY_EN.
module bus_mem_ctrl
    import bus_pkg::*;
#(
    parameter int DATA_W      = BUS_DATA_W,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] MEM_OUT,
    output logic              MEM_VALID,
    output logic              DR_LD,
    output logic              WR_DONE,
    output logic              BUSY,
`ifdef BUS_MEM_PARITY_EN
    output logic              PAR_ERR,
`endif
    output logic              REQ_ERR
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                  state_r;
    op_e                     op_r;
    logic [WAIT_CNT_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [DATA_W-1:0]       data_r;
    logic                    busy_r;
    logic                    valid_r;
    logic                    dr_ld_r;
    logic                    wr_done_r;
    logic                    req_err_r;
    logic                    mem_we_s;
    logic                    mem_re_s;
    logic                    accept_s;

    // Array strobes come only from XFER; a reset on the same edge suppresses the access.
    always_comb begin
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        accept_s = RD ^ WR;
        if (!reset && (state_r == XFER)) begin
            mem_we_s = (op_r == OP_WR);
            mem_re_s = (op_r == OP_RD);
        end else begin
            mem_we_s = 1'b0;
            mem_re_s = 1'b0;
        end
    end

    // Request capture, wait-state sequencing and single-cycle completion pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r   <= IDLE;
            op_r      <= OP_RD;
            cnt_r     <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            dr_ld_r   <= 1'b0;
            wr_done_r <= 1'b0;
            req_err_r <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            dr_ld_r   <= 1'b0;
            wr_done_r <= 1'b0;
            req_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r <= ADDR_IN;
                        data_r <= DATA_IN;
                        op_r   <= RD ? OP_RD : OP_WR;
                        busy_r <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_INIT;
                        end else begin
                            state_r <= XFER;
                            cnt_r   <= '0;
                        end
                    end else begin
                        req_err_r <= RD && WR;
                    end
                end
                WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= XFER;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                XFER: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (op_r == OP_RD) begin
                        valid_r <= 1'b1;
                        dr_ld_r <= 1'b1;
                    end else begin
                        wr_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    bus_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (CLK),
        .reset   (reset),
        .we      (mem_we_s),
        .re      (mem_re_s),
        .addr    (addr_r),
        .wdata   (data_r),
`ifdef BUS_MEM_PARITY_EN
        .par_err (PAR_ERR),
`endif
        .rdata   (MEM_OUT)
    );

    assign MEM_VALID = valid_r;
    assign DR_LD     = dr_ld_r;
    assign WR_DONE   = wr_done_r;
    assign BUSY      = busy_r;
    assign REQ_ERR   = req_err_r;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Scoreboard bench for bus_mem_ctrl: stimulus pushes expected responses, a negedge monitor checks them.
// Covers BUS_MEM_PARITY_EN when that macro is defined for the build.
module tb_bus_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int WC = 1;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          RD = 1'b0;
    logic          WR = 1'b0;
    logic [AW-1:0] ADDR_IN = '0;
    logic [DW-1:0] DATA_IN = '0;
    logic [DW-1:0] MEM_OUT;
    logic          MEM_VALID, DR_LD, WR_DONE, BUSY, REQ_ERR;
`ifdef BUS_MEM_PARITY_EN
    logic          PAR_ERR;
`endif

    bus_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
        .CLK(CLK), .reset(reset), .RD(RD), .WR(WR), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
        .MEM_OUT(MEM_OUT), .MEM_VALID(MEM_VALID), .DR_LD(DR_LD), .WR_DONE(WR_DONE),
        .BUSY(BUSY),
`ifdef BUS_MEM_PARITY_EN
        .PAR_ERR(PAR_ERR),
`endif
        .REQ_ERR(REQ_ERR)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = read completion, 1 = write completion, 2 = request error
    typedef struct {
        int          kind;
        int          due;
        logic [DW-1:0] data;
        logic        par;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [4096];
    bit            par_flip [4096];
    logic [AW-1:0] pool [18];

    int            cyc = 0;
    logic          rst_seen = 1'b0;
    int            last_rst = -1000;
    int            free_edge = 0;
    int            acc_edge = -100;
    bit            pend_v = 1'b0;
    int            pend_due = 0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    logic [DW-1:0] exp_out = '0;
    int            total = 0;
    int            bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) rst_seen <= reset;

    function automatic void commit_pending();
        if (pend_v) begin
            ref_mem[pend_a] = pend_d;
            par_flip[pend_a] = 1'b0;
            pend_v = 1'b0;
        end
    endfunction

    // Decide what the request sampled at edge e must produce.
    function automatic void model_sample(input int e);
        exp_t t;
        if (e >= free_edge) begin
            commit_pending();
            if (RD && WR) begin
                t = '{2, e, '0, 1'b0};
                sb.push_back(t);
            end else if (RD || WR) begin
                acc_edge  = e;
                free_edge = e + WC + 2;
                if (RD) begin
                    t = '{0, e + 1 + WC, ref_mem[ADDR_IN], par_flip[ADDR_IN]};
                end else begin
                    pend_v   = 1'b1;
                    pend_a   = ADDR_IN;
                    pend_d   = DATA_IN;
                    pend_due = e + 1 + WC;
                    t = '{1, e + 1 + WC, '0, 1'b0};
                end
                sb.push_back(t);
            end
        end
    endfunction

    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        RD = rd;
        WR = wr;
        ADDR_IN = a;
        DATA_IN = d;
        model_sample(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 12'($urandom), 16'($urandom));
    endtask

    task automatic do_reset(input int n);
        int c0;
        @(posedge CLK);
        #1;
        c0 = cyc;
        reset = 1'b1;
        RD = 1'b0;
        WR = 1'b0;
        while (sb.size() > 0 && sb[$].due > c0) void'(sb.pop_back());
        if (pend_v && pend_due <= c0) commit_pending();
        pend_v = 1'b0;
        free_edge = c0 + n + 1;
        repeat (n - 1) @(posedge CLK);
    endtask

    // Monitor: pops every expectation due this cycle and compares all outputs.
    always @(negedge CLK) begin : monitor
        logic          ev, ew, ee, ep, exp_busy;
        logic [DW-1:0] ed;
        exp_t          t;
        if (cyc > 0) begin
            if (rst_seen) begin
                last_rst = cyc;
                exp_out  = '0;
                total++;
                if ({MEM_OUT, MEM_VALID, DR_LD, WR_DONE, BUSY, REQ_ERR} != '0) begin
                    bad++;
                    $display("FAIL reset_outputs cyc=%0d got out=%h v=%b ld=%b wd=%b busy=%b re=%b want all 0",
                             cyc, MEM_OUT, MEM_VALID, DR_LD, WR_DONE, BUSY, REQ_ERR);
                end
            end else begin
                ev = 1'b0; ew = 1'b0; ee = 1'b0; ep = 1'b0; ed = exp_out;
                while (sb.size() > 0 && sb[0].due <= cyc) begin
                    t = sb.pop_front();
                    if (t.due < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL missed_event cyc=%0d kind=%0d due=%0d", cyc, t.kind, t.due);
                    end else begin
                        case (t.kind)
                            0:       begin ev = 1'b1; ed = t.data; ep = t.par; end
                            1:       ew = 1'b1;
                            default: ee = 1'b1;
                        endcase
                    end
                end
                exp_busy = (acc_edge > last_rst) && (cyc >= acc_edge) && (cyc <= acc_edge + WC);
                total++;
                if (BUSY !== exp_busy) begin
                    bad++;
                    $display("FAIL busy cyc=%0d got=%b want=%b", cyc, BUSY, exp_busy);
                end
                if (ev || ew || ee || MEM_VALID || DR_LD || WR_DONE || REQ_ERR) begin
                    total++;
                    if ({MEM_VALID, DR_LD, WR_DONE, REQ_ERR} !== {ev, ev, ew, ee}) begin
                        bad++;
                        $display("FAIL pulses cyc=%0d got v/ld/wd/re=%b%b%b%b want=%b%b%b%b",
                                 cyc, MEM_VALID, DR_LD, WR_DONE, REQ_ERR, ev, ev, ew, ee);
                    end
                end
                if (ev) exp_out = ed;
                total++;
                if (MEM_OUT !== exp_out) begin
                    bad++;
                    $display("FAIL mem_out cyc=%0d got=%h want=%h", cyc, MEM_OUT, exp_out);
                end
`ifdef BUS_MEM_PARITY_EN
                total++;
                if (PAR_ERR !== (ev & ep)) begin
                    bad++;
                    $display("FAIL par_err cyc=%0d got=%b want=%b", cyc, PAR_ERR, ev & ep);
                end
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) pool[i] = 12'(i);
        pool[16] = 12'hFFF;
        pool[17] = 12'h800;
        for (int i = 0; i < 4096; i++) par_flip[i] = 1'b0;

        do_reset(2);

        // Give every pool address a known value.
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b1, pool[i], 16'($urandom));
            idle(WC + 1);
        end

        // Write then read 0x00A.
        step(1'b0, 1'b1, 12'h00A, 16'hBEEF);
        idle(WC + 1);
        step(1'b1, 1'b0, 12'h00A, 16'h0000);
        idle(WC + 1);

        // Both requests at once: error pulse only, memory unchanged.
        step(1'b1, 1'b1, 12'h00A, 16'h1111);
        idle(1);
        step(1'b1, 1'b0, 12'h00A, 16'h0000);
        idle(WC + 1);

        // Requests and address changes while busy are ignored.
        step(1'b1, 1'b0, 12'h009, 16'h0000);
        step(1'b0, 1'b1, 12'h005, 16'h1234);
        step(1'b0, 1'b1, 12'h007, 16'h5678);
        idle(WC + 1);
        step(1'b1, 1'b0, 12'h005, 16'h0000);
        idle(WC + 1);

        // Reset while the write to 0x003 sits in WAIT.
        step(1'b0, 1'b1, 12'h003, 16'hDEAD);
        do_reset(1);
        step(1'b1, 1'b0, 12'h003, 16'h0000);
        idle(WC + 1);

        // Read requests held every cycle: accepted exactly in each valid cycle.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, pool[i], 16'($urandom));
        idle(WC + 2);

`ifdef BUS_MEM_PARITY_EN
        u_dut.u_array.mem_r[12'h005] = u_dut.u_array.mem_r[12'h005] ^ 17'h00001;
        ref_mem[12'h005] = ref_mem[12'h005] ^ 16'h0001;
        par_flip[12'h005] = 1'b1;
        step(1'b1, 1'b0, 12'h005, 16'h0000);
        idle(WC + 1);
        step(1'b1, 1'b0, 12'h006, 16'h0000);
        idle(WC + 2);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                step((r < 45) || (r >= 92 && r < 96),
                     (r >= 45 && r < 96),
                     pool[$urandom_range(0, 17)], 16'($urandom));
            end
        end

        idle(WC + 4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending expectations want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
